// File: rtl/ctrl_pkg.sv
// Shared types and elaboration-time helpers for the line buffer frame sequencer.
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Minimum of 1 so a range of 1 still yields a legal vector width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int out_dim(input int size, input int k, input int s);
        return (size - k) / s + 1;
    endfunction

endpackage

// File: rtl/win_pos_counter.sv
// One axis of the raster position: position, stride phase, in-range flag and
// output-window index, all updated incrementally.
module win_pos_counter
    import ctrl_pkg::*;
#(
    parameter int SIZE   = 7,
    parameter int KERNEL = 3,
    parameter int STRIDE = 1,
    parameter int OUT_N  = out_dim(SIZE, KERNEL, STRIDE),
    parameter int PW     = clog2(SIZE),
    parameter int HW     = clog2(STRIDE),
    parameter int IW     = clog2(OUT_N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic          wrap_i,
    output logic [PW-1:0] pos_o,
    output logic [HW-1:0] ph_o,
    output logic          legal_o,
    output logic [IW-1:0] idx_o
);

    localparam logic [PW-1:0] FIRST    = PW'(KERNEL - 1);
    localparam logic [HW-1:0] PH_LAST  = HW'(STRIDE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(OUT_N - 1);

    logic [PW-1:0] pos_q, pos_d;
    logic [HW-1:0] ph_q, ph_d;
    logic [IW-1:0] idx_q, idx_d;

    // legal_o only says the kernel fits on this axis; phase alignment is
    // combined by the caller so both axes are checked together.
    assign legal_o = (pos_q >= FIRST);
    assign pos_o   = pos_q;
    assign ph_o    = ph_q;
    assign idx_o   = idx_q;

    always_comb begin
        pos_d = pos_q;
        ph_d  = ph_q;
        idx_d = idx_q;
        if (clr_i || (en_i && wrap_i)) begin
            pos_d = '0;
            ph_d  = '0;
            idx_d = '0;
        end else if (en_i) begin
            pos_d = pos_q + PW'(1);
            if (legal_o) begin
                ph_d = (ph_q == PH_LAST) ? '0 : ph_q + HW'(1);
            end
            // idx_q always holds the index of the next aligned position.
            if (legal_o && (ph_q == '0) && (idx_q != IDX_LAST)) begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q <= '0;
            ph_q  <= '0;
            idx_q <= '0;
        end else begin
            pos_q <= pos_d;
            ph_q  <= ph_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Frame sequencer for the 3x3 line buffer: forwards the pixel stream, clears
// the buffer per frame and flags legal windows to the conv engine.
//
// state | meaning
// IDLE  | waiting for start
// CLR   | one-cycle line buffer clear, counters zeroed
// RUN   | accepting pixels
// DRAIN | last pixel in, waiting for the final window to be taken
// DONE  | one-cycle frame_done pulse
module line_buffer_ctrl
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 7,
    parameter int HEIGHT     = 7,
    parameter int KERNEL     = 3,
    parameter int STRIDE     = 1
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic                                              s_valid,
    input  logic [DATA_WIDTH-1:0]                             s_data,
    output logic                                              s_ready,
    output logic                                              lb_valid,
    output logic [DATA_WIDTH-1:0]                             lb_data,
    output logic                                              lb_clear,
    output logic                                              win_valid,
    input  logic                                              win_ready,
    output logic [clog2(out_dim(HEIGHT, KERNEL, STRIDE))-1:0] out_row,
    output logic [clog2(out_dim(WIDTH, KERNEL, STRIDE))-1:0]  out_col,
    output logic                                              busy,
    output logic                                              frame_done
);

    localparam int OUT_W = out_dim(WIDTH, KERNEL, STRIDE);
    localparam int OUT_H = out_dim(HEIGHT, KERNEL, STRIDE);
    localparam int CW    = clog2(OUT_W);
    localparam int RW    = clog2(OUT_H);
    localparam int PCW   = clog2(WIDTH);
    localparam int PRW   = clog2(HEIGHT);
    localparam int HW    = clog2(STRIDE);

    state_t         state_q, state_d;
    logic           win_valid_q, win_valid_d;
    logic [RW-1:0]  out_row_q, out_row_d;
    logic [CW-1:0]  out_col_q, out_col_d;

    logic           accept, clr, col_last, row_last, legal_beat;
    logic [PCW-1:0] col_pos;
    logic [PRW-1:0] row_pos;
    logic [HW-1:0]  col_ph, row_ph;
    logic           col_in, row_in;
    logic [CW-1:0]  col_idx;
    logic [RW-1:0]  row_idx;

    assign clr        = (state_q == CLR);
    // A pending, untaken window blocks the stream so the buffer outputs hold.
    assign s_ready    = (state_q == RUN) && (!win_valid_q || win_ready);
    assign accept     = s_valid && s_ready;
    assign lb_valid   = accept;
    assign lb_data    = s_data;
    assign lb_clear   = clr;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign win_valid  = win_valid_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;

    assign col_last   = (col_pos == PCW'(WIDTH - 1));
    assign row_last   = (row_pos == PRW'(HEIGHT - 1));
    assign legal_beat = accept && col_in && row_in && (col_ph == '0) && (row_ph == '0);

    win_pos_counter #(
        .SIZE   (WIDTH),
        .KERNEL (KERNEL),
        .STRIDE (STRIDE)
    ) u_col (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .en_i    (accept),
        .wrap_i  (col_last),
        .pos_o   (col_pos),
        .ph_o    (col_ph),
        .legal_o (col_in),
        .idx_o   (col_idx)
    );

    win_pos_counter #(
        .SIZE   (HEIGHT),
        .KERNEL (KERNEL),
        .STRIDE (STRIDE)
    ) u_row (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .en_i    (accept && col_last),
        .wrap_i  (row_last),
        .pos_o   (row_pos),
        .ph_o    (row_ph),
        .legal_o (row_in),
        .idx_o   (row_idx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CLR;
            CLR:     state_d = RUN;
            RUN:     if (accept && col_last && row_last) state_d = DRAIN;
            DRAIN:   if (!win_valid_q || win_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        win_valid_d = win_valid_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        if (legal_beat) begin
            win_valid_d = 1'b1;
            out_row_d   = row_idx;
            out_col_d   = col_idx;
        end else if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            win_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            win_valid_q <= win_valid_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: stride-1 and stride-2 instances, expected windows
// derived from raster arithmetic on the accepted pixel indices.
module tb_line_buffer_ctrl;

    typedef struct {
        int r;
        int c;
    } win_t;

    logic        clk = 1'b0;
    logic        rst, start, s_valid, win_ready, sel;
    logic [31:0] s_data;

    logic        start1, start2, sv1, sv2;
    logic        rdy1, lbv1, clr1, wv1, busy1, fd1;
    logic        rdy2, lbv2, clr2, wv2, busy2, fd2;
    logic [31:0] lbd1, lbd2;
    logic [2:0]  row1, col1;
    logic [1:0]  row2, col2;

    logic        m_ready, m_lbv, m_clr, m_wv, m_busy, m_fd;
    logic [31:0] m_lbd;
    logic [2:0]  m_row, m_col;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // The idle instance sees no start or valid, so it stays parked in IDLE.
    assign start1 = start & ~sel;
    assign sv1    = s_valid & ~sel;
    assign start2 = start & sel;
    assign sv2    = s_valid & sel;

    line_buffer_ctrl #(.STRIDE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .s_valid(sv1), .s_data(s_data),
        .s_ready(rdy1), .lb_valid(lbv1), .lb_data(lbd1), .lb_clear(clr1),
        .win_valid(wv1), .win_ready(win_ready), .out_row(row1), .out_col(col1),
        .busy(busy1), .frame_done(fd1)
    );

    line_buffer_ctrl #(.STRIDE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .s_valid(sv2), .s_data(s_data),
        .s_ready(rdy2), .lb_valid(lbv2), .lb_data(lbd2), .lb_clear(clr2),
        .win_valid(wv2), .win_ready(win_ready), .out_row(row2), .out_col(col2),
        .busy(busy2), .frame_done(fd2)
    );

    always_comb begin
        if (sel) begin
            m_ready = rdy2; m_lbv = lbv2; m_lbd = lbd2; m_clr = clr2;
            m_wv = wv2; m_busy = busy2; m_fd = fd2;
            m_row = {1'b0, row2}; m_col = {1'b0, col2};
        end else begin
            m_ready = rdy1; m_lbv = lbv1; m_lbd = lbd1; m_clr = clr1;
            m_wv = wv1; m_busy = busy1; m_fd = fd1;
            m_row = row1; m_col = col1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"},    32'(m_ready), 0);
        check({tag, "_lb_valid"},   32'(m_lbv),   0);
        check({tag, "_lb_data"},    m_lbd,        0);
        check({tag, "_lb_clear"},   32'(m_clr),   0);
        check({tag, "_win_valid"},  32'(m_wv),    0);
        check({tag, "_out_row"},    32'(m_row),   0);
        check({tag, "_out_col"},    32'(m_col),   0);
        check({tag, "_busy"},       32'(m_busy),  0);
        check({tag, "_frame_done"}, 32'(m_fd),    0);
    endtask

    // One frame on the selected instance. rnd randomises s_valid/win_ready,
    // stall holds win_ready low 3 cycles at the first window, mid_start pulses
    // start during RUN, abort_at >= 0 resets right after that pixel is taken.
    task automatic run_frame(input bit rnd, input bit stall, input bit mid_start, input int abort_at);
        win_t q[$];
        int   stride, outs, pix, clears, dones, hs_dut, stall_left, r, c;
        bit   seen_wv, saw_done, finished, clear_late, mid_done, acc, wv_exp, ready_exp;
        stride = sel ? 2 : 1;
        outs = (7 - 3) / stride + 1;
        pix = 0; clears = 0; dones = 0; hs_dut = 0; stall_left = 0;
        seen_wv = 0; saw_done = 0; finished = 0; clear_late = 0; mid_done = 0;
        @(negedge clk);
        start = 1'b1; s_valid = 1'b0; win_ready = 1'b1;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            if (saw_done) begin
                check("busy_after_done", 32'(m_busy), 0);
                check("frame_done_single", 32'(m_fd), 0);
                finished = 1;
            end else begin
                if (m_clr) begin
                    clears++;
                    if (pix != 0) clear_late = 1;
                end
                if (m_fd) begin
                    dones++;
                    saw_done = 1;
                end
                wv_exp = (q.size() != 0);
                check("win_valid", 32'(m_wv), 32'(wv_exp));
                if (wv_exp) begin
                    check("out_row", 32'(m_row), q[0].r);
                    check("out_col", 32'(m_col), q[0].c);
                end
                if (abort_at >= 0 && pix > abort_at) begin
                    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; win_ready = 1'b0;
                    @(negedge clk);
                    check_all_zero("abort");
                    rst = 1'b0;
                    finished = 1;
                end else begin
                    start = mid_start && (pix == 30) && !mid_done;
                    if (start) mid_done = 1;
                    if (stall && wv_exp && !seen_wv) begin
                        seen_wv = 1;
                        stall_left = 3;
                    end
                    if (stall_left > 0) begin
                        win_ready = 1'b0;
                        stall_left--;
                    end else begin
                        win_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                    end
                    s_valid = (pix < 49) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
                    s_data = 32'hA500_0000 + 32'(pix);
                    #1;
                    ready_exp = (clears > 0) && !m_clr && (pix < 49) && (!wv_exp || win_ready);
                    check("s_ready", 32'(m_ready), 32'(ready_exp));
                    acc = s_valid && m_ready;
                    check("lb_valid", 32'(m_lbv), 32'(acc));
                    if (acc) check("lb_data", m_lbd, s_data);
                    if (m_wv && win_ready) hs_dut++;
                    if (wv_exp && win_ready) void'(q.pop_front());
                    if (acc) begin
                        r = pix / 7;
                        c = pix % 7;
                        if (r >= 2 && c >= 2 && (r - 2) % stride == 0 && (c - 2) % stride == 0)
                            q.push_back('{r: (r - 2) / stride, c: (c - 2) / stride});
                        pix++;
                    end
                end
            end
        end
        start = 1'b0; s_valid = 1'b0; win_ready = 1'b1;
        check("frame_finished", 32'(finished), 1);
        if (abort_at < 0) begin
            check("lb_clear_count", clears, 1);
            check("clear_before_first_beat", 32'(clear_late), 0);
            check("frame_done_count", dones, 1);
            check("window_count", hs_dut, outs * outs);
            check("pixels_accepted", pix, 49);
        end else begin
            check("abort_no_frame_done", dones, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; win_ready = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset_win_valid_s2", 32'(wv2), 0);
        check("reset_busy_s2", 32'(busy2), 0);
        rst = 1'b0;

        sel = 1'b0; run_frame(1'b0, 1'b0, 1'b0, -1);
        sel = 1'b1; run_frame(1'b0, 1'b0, 1'b0, -1);
        sel = 1'b0; run_frame(1'b0, 1'b1, 1'b0, -1);
        run_frame(1'b1, 1'b0, 1'b0, -1);
        run_frame(1'b0, 1'b0, 1'b0, 20);
        run_frame(1'b0, 1'b0, 1'b1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
